// File: rtl/program_loader_pkg.sv
// Shared control encodings for the program loader: FSM state codes and state type.
package program_loader_pkg;

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t ST_IDLE  = 2'd0;
  localparam loader_state_t ST_LOAD  = 2'd1;
  localparam loader_state_t ST_DRAIN = 2'd2;
  localparam loader_state_t ST_START = 2'd3;

endpackage

// File: rtl/program_loader.sv
// Streams a program image into BRAM through a byte-enabled write port, then
// pulses start with the load base as the core's start PC.
//
//   state | meaning
//   IDLE  | waiting for load_req; bad requests pulse error
//   LOAD  | accepting stream words; the cycle after the last word is its write cycle
//   DRAIN | final write has landed; nothing on the port
//   START | start/done pulse, program_address valid
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 11
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_req,
  input  logic [ADDRESS_BITS-1:0]     base_address,
  input  logic [MEM_ADDRESS_BITS:0]   word_count,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        mem_write,
  output logic [MEM_ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH/8-1:0]     mem_byte_en,
  output logic [DATA_WIDTH-1:0]       mem_data,
  output logic                        start,
  output logic [ADDRESS_BITS-1:0]     program_address,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [DATA_WIDTH-1:0]       checksum
);

  localparam logic [MEM_ADDRESS_BITS+1:0] DEPTH = {2'b01, {MEM_ADDRESS_BITS{1'b0}}};

  loader_state_t                 state;
  logic [MEM_ADDRESS_BITS:0]     remaining;
  logic [MEM_ADDRESS_BITS-1:0]   next_index;
  logic [ADDRESS_BITS-1:0]       base_q;
  logic [MEM_ADDRESS_BITS-1:0]   req_index;
  logic [MEM_ADDRESS_BITS+1:0]   req_end;
  logic                          req_ok;
  logic                          handshake;

  assign req_index = base_address[MEM_ADDRESS_BITS+1:2];
  // Widened by two bits so a full-depth request does not overflow the compare.
  assign req_end   = {2'b00, req_index} + {1'b0, word_count};
  assign req_ok    = (word_count != '0) && (base_address[1:0] == 2'b00) && (req_end <= DEPTH);

  // remaining is a down-counter; reaching zero marks the last word's write cycle.
  assign in_ready    = (state == ST_LOAD) && (remaining != '0);
  assign handshake   = in_valid && in_ready;
  assign busy        = (state != ST_IDLE);
  assign start       = (state == ST_START);
  assign done        = (state == ST_START);
  assign mem_byte_en = {(DATA_WIDTH/8){mem_write}};

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      remaining       <= '0;
      next_index      <= '0;
      base_q          <= '0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_data        <= '0;
      checksum        <= '0;
      program_address <= '0;
      error           <= 1'b0;
    end else begin
      mem_write <= handshake;
      error     <= 1'b0;

      if (handshake) begin
        mem_address <= next_index;
        mem_data    <= in_data;
        next_index  <= next_index + MEM_ADDRESS_BITS'(1);
        remaining   <= remaining - (MEM_ADDRESS_BITS+1)'(1);
        checksum    <= checksum + in_data;
      end

      case (state)
        ST_IDLE: begin
          if (load_req) begin
            if (req_ok) begin
              base_q     <= base_address;
              next_index <= req_index;
              remaining  <= word_count;
              checksum   <= '0;
              state      <= ST_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (remaining == '0) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          program_address <= base_q;
          state           <= ST_START;
        end
        ST_START: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected BRAM writes are queued at each
// handshake and matched cycle-exactly by a write monitor.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_req;
  logic [31:0] base_address;
  logic [11:0] word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_write;
  logic [10:0] mem_address;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data;
  logic        start;
  logic [31:0] program_address;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  program_loader dut (
    .clock           (clock),
    .reset           (reset),
    .load_req        (load_req),
    .base_address    (base_address),
    .word_count      (word_count),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_byte_en     (mem_byte_en),
    .mem_data        (mem_data),
    .start           (start),
    .program_address (program_address),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .checksum        (checksum)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [10:0] idx;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  logic [31:0] img[$];
  int          cyc = 0;
  int          total = 0;
  int          failed = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: either the queued write is due now, or the port must be quiet.
  always @(negedge clock) begin
    while (sb.size() != 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      check("missed_write_idx", 64'(mem_address), 64'(mon_e.idx) + 64'h1_0000);
    end
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check("mem_write", mem_write, 1);
      check("mem_address", mem_address, mon_e.idx);
      check("mem_data", mem_data, mon_e.data);
      check("mem_byte_en", mem_byte_en, 4'hF);
    end else begin
      check("unexpected_write", mem_write, 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_mem_address"}, mem_address, 0);
    check({tag, "_mem_byte_en"}, mem_byte_en, 0);
    check({tag, "_mem_data"}, mem_data, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_program_address"}, program_address, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_checksum"}, checksum, 0);
  endtask

  task automatic run_load(input logic [31:0] base, input bit gaps, input bit mid_req);
    logic [31:0] sum;
    logic [10:0] idx;
    int          n;
    int          guard;
    sum = 32'h0;
    idx = base[12:2];
    n   = img.size();
    load_req     = 1'b1;
    base_address = base;
    word_count   = 12'(n);
    tick();
    load_req = 1'b0;
    check("busy_after_req", busy, 1);
    check("error_after_req", error, 0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = img[i];
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 10) begin
        tick();
        guard++;
      end
      check("in_ready_load", in_ready, 1);
      sb.push_back('{idx, img[i], cyc + 1});
      idx = idx + 11'd1;
      sum = sum + img[i];
      if (mid_req && i == 1) begin
        load_req     = 1'b1;
        base_address = 32'h100;
        word_count   = 12'd1;
      end
      tick();
      load_req = 1'b0;
      if (mid_req && i == 1) begin
        check("ignored_req_error", error, 0);
        check("ignored_req_busy", busy, 1);
      end
      if (gaps && i != n - 1) begin
        in_valid = 1'b0;
        in_data  = 32'hBAD0BAD0;
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = 32'h5A5A5A5A;
    check("in_ready_drop", in_ready, 0);
    check("start_c1", start, 0);
    tick();
    check("in_ready_drain", in_ready, 0);
    check("start_c2", start, 0);
    tick();
    in_valid = 1'b0;
    check("start_c3", start, 1);
    check("done_c3", done, 1);
    check("busy_c3", busy, 1);
    check("program_address", program_address, base);
    check("checksum_start", checksum, sum);
    tick();
    check("start_after", start, 0);
    check("done_after", done, 0);
    check("busy_after", busy, 0);
    check("program_address_held", program_address, base);
    check("checksum_held", checksum, sum);
    check("scoreboard_empty", 32'(sb.size()), 0);
  endtask

  task automatic bad_req(input string tag, input logic [31:0] base, input logic [11:0] cnt);
    load_req     = 1'b1;
    base_address = base;
    word_count   = cnt;
    in_valid     = 1'b1;
    in_data      = 32'h12345678;
    tick();
    load_req = 1'b0;
    check({tag, "_error"}, error, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    tick();
    check({tag, "_error_clear"}, error, 0);
    check({tag, "_in_ready_idle"}, in_ready, 0);
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    load_req     = 1'b0;
    base_address = 32'h0;
    word_count   = 12'h0;
    in_valid     = 1'b0;
    in_data      = 32'h0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Four words, sustained valid.
    img = '{32'hDEADBEEF, 32'h1, 32'h2, 32'h3};
    run_load(32'h0, 1'b0, 1'b0);
    check("checksum_t1", checksum, 32'hDEADBEF5);

    // Same image with one-cycle gaps between words.
    run_load(32'h0, 1'b1, 1'b0);
    check("checksum_t2", checksum, 32'hDEADBEF5);

    bad_req("count_zero", 32'h0, 12'd0);
    bad_req("misaligned", 32'h2, 12'd1);
    bad_req("overflow", 32'h1FFC, 12'd2);

    // Largest legal load ending at the top word.
    img = '{};
    for (int i = 0; i < 2048; i++) img.push_back(32'(i) * 32'h01000193 + 32'h7);
    run_load(32'h0, 1'b0, 1'b0);

    // Single word at the very last index.
    img = '{32'hCAFEF00D};
    run_load(32'h1FFC, 1'b0, 1'b0);

    // Reset in the middle of a five-word load.
    img = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    load_req     = 1'b1;
    base_address = 32'h0;
    word_count   = 12'd5;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = img[i];
      check("mid_reset_in_ready", in_ready, 1);
      sb.push_back('{11'(i), img[i], cyc + 1});
      tick();
    end
    reset    = 1'b1;
    in_data  = img[2];
    tick();
    check_all_zero("mid_reset");
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_start_after_reset", start, 0);
      check("idle_after_reset", busy, 0);
    end

    img = '{32'hA0, 32'hB1, 32'hC2};
    run_load(32'h40, 1'b0, 1'b0);

    // A second load_req mid-stream must not disturb the running load.
    img = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    run_load(32'h80, 1'b0, 1'b1);

    tick();
    tick();
    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
